cpu_agu: RTL and testbench



---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_agu_if.sv | 44 ++++
 rtl/agu_page_adder.sv | 17 +
 rtl/cpu_agu.sv | 235 +++++++++++++++++++++++
 tb/tb_cpu_agu.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : cpu_pkg                                                         |
// | Purpose  : Shared definitions for the 6502-class effective-address unit:  |
// |            addressing-mode codes, AGU state encoding and the address/data  |
// |            width relationship.                                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int unsigned MODE_W = 3;

  // Addressing-mode codes carried on the mode bus
  localparam logic [MODE_W-1:0] AM_ZP   = 3'd0;
  localparam logic [MODE_W-1:0] AM_ZPX  = 3'd1;
  localparam logic [MODE_W-1:0] AM_ZPY  = 3'd2;
  localparam logic [MODE_W-1:0] AM_ABS  = 3'd3;
  localparam logic [MODE_W-1:0] AM_ABSX = 3'd4;
  localparam logic [MODE_W-1:0] AM_ABSY = 3'd5;
  localparam logic [MODE_W-1:0] AM_INDX = 3'd6;
  localparam logic [MODE_W-1:0] AM_INDY = 3'd7;

  // An address is exactly two data bytes (high byte : low byte)
  localparam int unsigned ADDR_PER_DATA = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PTR_LO = 3'd1,
    S_PTR_HI = 3'd2,
    S_FIX    = 3'd3,
    S_DONE   = 3'd4
  } agu_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_agu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: cpu_agu_if                                                      |
// | Purpose  : Request, pointer-read and result signals of the AGU.            |
// |   start/mode/force_fix/op_lo/op_hi/x_in/y_in : request from sequencer      |
// |   rd_req/rd_addr -> , rd_data/rd_valid <-     : pointer read handshake     |
// |   ea/ea_valid/page_cross/xcyc/busy            : result and status          |
// |   slave  : AGU side      master : sequencer / memory side                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface cpu_agu_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic                start;
  logic [MODE_W-1:0]   mode;
  logic                force_fix;
  logic [DATA_W-1:0]   op_lo;
  logic [DATA_W-1:0]   op_hi;
  logic [DATA_W-1:0]   x_in;
  logic [DATA_W-1:0]   y_in;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic [ADDR_W-1:0]   ea;
  logic                ea_valid;
  logic                page_cross;
  logic [1:0]          xcyc;
  logic                busy;

  modport slave (
    input  start, mode, force_fix, op_lo, op_hi, x_in, y_in, rd_data, rd_valid,
    output rd_req, rd_addr, ea, ea_valid, page_cross, xcyc, busy
  );

  modport master (
    output start, mode, force_fix, op_lo, op_hi, x_in, y_in, rd_data, rd_valid,
    input  rd_req, rd_addr, ea, ea_valid, page_cross, xcyc, busy
  );
endinterface : cpu_agu_if
`default_nettype wire

// File: rtl/agu_page_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : agu_page_adder                                                  |
// | Purpose  : Combinational DATA_W-bit adder returning {carry, sum}.          |
// |   a_i, b_i : addends             sum_o : {carry-out, sum}                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module agu_page_adder #(
  parameter int DATA_W = 8
) (
  input  wire logic [DATA_W-1:0] a_i,
  input  wire logic [DATA_W-1:0] b_i,
  output logic      [DATA_W:0]   sum_o
);
  assign sum_o = {1'b0, a_i} + {1'b0, b_i};
endmodule : agu_page_adder
`default_nettype wire

// File: rtl/cpu_agu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_agu                                                         |
// | Purpose  : Effective-address generator for ZP, ZP indexed, ABS, ABS        |
// |            indexed, (zp,X) and (zp),Y, with pointer fetch over a           |
// |            variable-latency read handshake and cycle accounting.           |
// |   clk, rst : clock, synchronous active-high reset                          |
// |   bus      : cpu_agu_if.slave (request, pointer read, result/status)       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cpu_agu
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter bit ZP_WRAP = 1'b1
) (
  input wire logic clk,
  input wire logic rst,
  cpu_agu_if.slave bus
);

  generate
    if (ADDR_W != ADDR_PER_DATA * DATA_W) begin : g_width_check
      $error("cpu_agu: ADDR_W must equal 2*DATA_W");
    end
  endgenerate

  localparam logic [DATA_W-1:0] c_zero_byte = '0;
  localparam logic [DATA_W-1:0] c_one_byte  = DATA_W'(1);

  agu_state_t          state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                force_q, force_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic                ea_valid_q, ea_valid_d;
  logic                page_cross_q, page_cross_d;
  logic [1:0]          xcyc_q, xcyc_d;
  logic                busy_q, busy_d;

  // Index adder: operand + index at request time, fetched low byte + Y
  // when completing a (zp),Y pointer.
  logic [DATA_W-1:0]   w_idx_a, w_idx_b, w_idx_sel;
  logic [DATA_W:0]     w_idx_res;
  logic                w_idx_c;
  logic [DATA_W-1:0]   w_idx_s;
  logic [DATA_W-1:0]   w_hi_base, w_hi_sum;
  logic [DATA_W-1:0]   w_zp_hi;
  logic [ADDR_W-1:0]   w_zp_idx_addr;

  // Pointer + 1 for the high-byte fetch
  logic [DATA_W:0]     w_inc_res;
  logic [DATA_W-1:0]   w_inc_hi;
  logic [ADDR_W-1:0]   w_ptr_inc;

  logic                w_rd_fire;
  logic                w_fix;
  logic [1:0]          w_xcyc_inc;

  assign w_idx_sel = (bus.mode == AM_ZPY || bus.mode == AM_ABSY) ? bus.y_in : bus.x_in;
  assign w_idx_a   = (state_q == S_PTR_HI) ? lo_q : bus.op_lo;
  assign w_idx_b   = (state_q == S_PTR_HI) ? y_q  : w_idx_sel;

  agu_page_adder #(.DATA_W(DATA_W)) u_idx_add (
    .a_i   (w_idx_a),
    .b_i   (w_idx_b),
    .sum_o (w_idx_res)
  );

  assign w_idx_c   = w_idx_res[DATA_W];
  assign w_idx_s   = w_idx_res[DATA_W-1:0];
  // Carry ripples into the high byte: operand high byte, or fetched pointer high
  assign w_hi_base = (state_q == S_PTR_HI) ? bus.rd_data : bus.op_hi;
  assign w_hi_sum  = w_hi_base + DATA_W'(w_idx_c);

  assign w_zp_hi       = ZP_WRAP ? c_zero_byte : DATA_W'(w_idx_c);
  assign w_zp_idx_addr = {w_zp_hi, w_idx_s};

  agu_page_adder #(.DATA_W(DATA_W)) u_ptr_inc (
    .a_i   (ptr_q[DATA_W-1:0]),
    .b_i   (c_one_byte),
    .sum_o (w_inc_res)
  );

  assign w_inc_hi  = ZP_WRAP ? ptr_q[ADDR_W-1:DATA_W]
                             : ptr_q[ADDR_W-1:DATA_W] + DATA_W'(w_inc_res[DATA_W]);
  assign w_ptr_inc = {w_inc_hi, w_inc_res[DATA_W-1:0]};

  // rd_valid only counts while a request is actually outstanding
  assign w_rd_fire  = rd_req_q & bus.rd_valid;
  assign w_fix      = w_idx_c | force_q;
  assign w_xcyc_inc = (xcyc_q == 2'd3) ? 2'd3 : xcyc_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= AM_ZP;
      y_q          <= '0;
      force_q      <= 1'b0;
      ptr_q        <= '0;
      lo_q         <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      ea_q         <= '0;
      ea_valid_q   <= 1'b0;
      page_cross_q <= 1'b0;
      xcyc_q       <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      y_q          <= y_d;
      force_q      <= force_d;
      ptr_q        <= ptr_d;
      lo_q         <= lo_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      ea_q         <= ea_d;
      ea_valid_q   <= ea_valid_d;
      page_cross_q <= page_cross_d;
      xcyc_q       <= xcyc_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    y_d          = y_q;
    force_d      = force_q;
    ptr_d        = ptr_q;
    lo_d         = lo_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    ea_d         = ea_q;
    page_cross_d = page_cross_q;
    xcyc_d       = xcyc_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d       = bus.mode;
          y_d          = bus.y_in;
          force_d      = bus.force_fix;
          page_cross_d = 1'b0;
          xcyc_d       = 2'd0;
          unique case (bus.mode)
            AM_ZP: begin
              ea_d    = {c_zero_byte, bus.op_lo};
              state_d = S_DONE;
            end
            AM_ZPX, AM_ZPY: begin
              ea_d    = w_zp_idx_addr;
              state_d = S_DONE;
            end
            AM_ABS: begin
              ea_d    = {bus.op_hi, bus.op_lo};
              state_d = S_DONE;
            end
            AM_ABSX, AM_ABSY: begin
              ea_d         = {w_hi_sum, w_idx_s};
              page_cross_d = w_idx_c;
              // force_q is not yet loaded, so use the live request bit here
              state_d      = (w_idx_c | bus.force_fix) ? S_FIX : S_DONE;
            end
            AM_INDX: begin
              ptr_d     = w_zp_idx_addr;
              rd_req_d  = 1'b1;
              rd_addr_d = w_zp_idx_addr;
              state_d   = S_PTR_LO;
            end
            default: begin // AM_INDY
              ptr_d     = {c_zero_byte, bus.op_lo};
              rd_req_d  = 1'b1;
              rd_addr_d = {c_zero_byte, bus.op_lo};
              state_d   = S_PTR_LO;
            end
          endcase
        end
      end
      S_PTR_LO: begin
        xcyc_d = w_xcyc_inc;
        if (w_rd_fire) begin
          lo_d      = bus.rd_data;
          rd_addr_d = w_ptr_inc;
          state_d   = S_PTR_HI;
        end
      end
      S_PTR_HI: begin
        xcyc_d = w_xcyc_inc;
        if (w_rd_fire) begin
          rd_req_d = 1'b0;
          if (mode_q == AM_INDX) begin
            ea_d    = {bus.rd_data, lo_q};
            state_d = S_DONE;
          end else begin
            ea_d         = {w_hi_sum, w_idx_s};
            page_cross_d = w_idx_c;
            state_d      = w_fix ? S_FIX : S_DONE;
          end
        end
      end
      S_FIX: begin
        xcyc_d  = w_xcyc_inc;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        rd_req_d = 1'b0;
      end
    endcase

    // DONE always lasts one cycle, so entering it is the ea_valid pulse
    ea_valid_d = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  assign bus.rd_req     = rd_req_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.ea         = ea_q;
  assign bus.ea_valid   = ea_valid_q;
  assign bus.page_cross = page_cross_q;
  assign bus.xcyc       = xcyc_q;
  assign bus.busy       = busy_q;

endmodule : cpu_agu
`default_nettype wire

// File: tb/tb_cpu_agu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cpu_agu                                                      |
// | Purpose  : Directed self-checking bench for cpu_agu. A wrapping instance   |
// |            is driven with all modes plus a pointer memory with selectable  |
// |            read delay; a non-wrapping instance checks ZP carry behaviour.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cpu_agu;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_agu_if #(.DATA_W(8), .ADDR_W(16)) bus ();
  cpu_agu_if #(.DATA_W(8), .ADDR_W(16)) bus_nw ();

  cpu_agu #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cpu_agu #(.DATA_W(8), .ADDR_W(16), .ZP_WRAP(1'b0)) u_dut_nw (
    .clk (clk),
    .rst (rst),
    .bus (bus_nw)
  );

  // The non-wrapping instance sees the same requests but has no memory
  assign bus_nw.start     = bus.start;
  assign bus_nw.mode      = bus.mode;
  assign bus_nw.force_fix = bus.force_fix;
  assign bus_nw.op_lo     = bus.op_lo;
  assign bus_nw.op_hi     = bus.op_hi;
  assign bus_nw.x_in      = bus.x_in;
  assign bus_nw.y_in      = bus.y_in;
  assign bus_nw.rd_data   = 8'h00;
  assign bus_nw.rd_valid  = 1'b0;

  // Pointer memory with programmable wait cycles per read
  logic [7:0] mem [256];
  int         rd_delay    = 0;
  int         wcnt        = 0;
  logic       extra_valid = 1'b0;

  always_comb begin
    bus.rd_valid = (bus.rd_req && (wcnt >= rd_delay)) || extra_valid;
    bus.rd_data  = mem[bus.rd_addr[7:0]];
  end

  always @(posedge clk) begin
    if (bus.rd_req && !bus.rd_valid) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  // Monitors: ea_valid pulse count, read address log, address stability
  int          n_ev     = 0;
  int          n_unstab = 0;
  logic [15:0] addr_log[$];
  logic        prev_req   = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_addr  = '0;

  always @(negedge clk) begin
    if (bus.ea_valid) n_ev++;
    if (bus.rd_req && !(prev_req && !prev_valid)) addr_log.push_back(bus.rd_addr);
    if (prev_req && !prev_valid && bus.rd_req && bus.rd_addr != prev_addr) n_unstab++;
    prev_req   = bus.rd_req;
    prev_valid = bus.rd_valid;
    prev_addr  = bus.rd_addr;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one sampling edge; returns 1 time unit
  // after that edge (cycle 1 relative to the start edge)
  task automatic issue(input logic [2:0] m, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] x, input logic [7:0] y, input logic ff);
    bus.mode      = m;
    bus.op_lo     = lo;
    bus.op_hi     = hi;
    bus.x_in      = x;
    bus.y_in      = y;
    bus.force_fix = ff;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] m, input logic [7:0] lo, input logic [7:0] hi,
                        input logic [7:0] x, input logic [7:0] y, input logic ff,
                        output int lat);
    issue(m, lo, hi, x, y, ff);
    lat = 1;
    while (!bus.ea_valid && lat < 30) begin
      tick();
      lat++;
    end
    tick(); // back to IDLE before the next request
  endtask

  int lat;

  initial begin
    bus.start = 1'b0; bus.mode = AM_ZP; bus.force_fix = 1'b0;
    bus.op_lo = '0; bus.op_hi = '0; bus.x_in = '0; bus.y_in = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
    mem[8'h40] = 8'hF0; mem[8'h41] = 8'h20;

    rst = 1'b1;
    tick(); tick();
    chk("rst_rd_req",  32'(bus.rd_req), 32'h0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'h0);
    chk("rst_ea",      32'(bus.ea), 32'h0);
    chk("rst_ea_valid", 32'(bus.ea_valid), 32'h0);
    chk("rst_pc",      32'(bus.page_cross), 32'h0);
    chk("rst_xcyc",    32'(bus.xcyc), 32'h0);
    chk("rst_busy",    32'(bus.busy), 32'h0);
    rst = 1'b0;
    tick();

    // ZPX wraps in page 0 (and carries on the non-wrapping instance)
    run_op(AM_ZPX, 8'hF0, 8'h00, 8'h20, 8'h00, 1'b0, lat);
    chk("zpx_ea",   32'(bus.ea), 32'h0010);
    chk("zpx_lat",  32'(lat), 32'd1);
    chk("zpx_pc",   32'(bus.page_cross), 32'h0);
    chk("zpx_xcyc", 32'(bus.xcyc), 32'h0);
    chk("zpx_nw_ea", 32'(bus_nw.ea), 32'h0110);

    run_op(AM_ZP, 8'h42, 8'h77, 8'h11, 8'h22, 1'b0, lat);
    chk("zp_ea",  32'(bus.ea), 32'h0042);
    chk("zp_lat", 32'(lat), 32'd1);

    run_op(AM_ZPY, 8'h80, 8'h00, 8'h77, 8'h05, 1'b0, lat);
    chk("zpy_ea", 32'(bus.ea), 32'h0085);

    run_op(AM_ABS, 8'h34, 8'h12, 8'h55, 8'h66, 1'b0, lat);
    chk("abs_ea",  32'(bus.ea), 32'h1234);
    chk("abs_lat", 32'(lat), 32'd1);

    run_op(AM_ABSX, 8'hFF, 8'h12, 8'h01, 8'h00, 1'b0, lat);
    chk("absx_ea",   32'(bus.ea), 32'h1300);
    chk("absx_pc",   32'(bus.page_cross), 32'h1);
    chk("absx_xcyc", 32'(bus.xcyc), 32'h1);
    chk("absx_lat",  32'(lat), 32'd2);

    run_op(AM_ABSX, 8'h00, 8'h12, 8'h00, 8'h00, 1'b1, lat);
    chk("absx_ff_ea",   32'(bus.ea), 32'h1200);
    chk("absx_ff_pc",   32'(bus.page_cross), 32'h0);
    chk("absx_ff_xcyc", 32'(bus.xcyc), 32'h1);
    chk("absx_ff_lat",  32'(lat), 32'd2);

    run_op(AM_ABSY, 8'h10, 8'h12, 8'hF0, 8'h05, 1'b0, lat);
    chk("absy_ea",   32'(bus.ea), 32'h1215);
    chk("absy_xcyc", 32'(bus.xcyc), 32'h0);
    chk("absy_lat",  32'(lat), 32'd1);

    // (zp,X) pointer straddling the end of page 0
    addr_log.delete();
    run_op(AM_INDX, 8'hFE, 8'h00, 8'h01, 8'h00, 1'b0, lat);
    chk("indx_ea",    32'(bus.ea), 32'h1234);
    chk("indx_lat",   32'(lat), 32'd3);
    chk("indx_xcyc",  32'(bus.xcyc), 32'h2);
    chk("indx_nrd",   32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      chk("indx_addr0", 32'(addr_log[0]), 32'h00FF);
      chk("indx_addr1", 32'(addr_log[1]), 32'h0000);
    end

    run_op(AM_INDY, 8'h40, 8'h00, 8'h00, 8'h20, 1'b0, lat);
    chk("indy_ea",   32'(bus.ea), 32'h2110);
    chk("indy_pc",   32'(bus.page_cross), 32'h1);
    chk("indy_xcyc", 32'(bus.xcyc), 32'h3);
    chk("indy_lat",  32'(lat), 32'd4);

    run_op(AM_INDY, 8'h40, 8'h00, 8'h00, 8'h05, 1'b0, lat);
    chk("indy_nc_ea",   32'(bus.ea), 32'h20F5);
    chk("indy_nc_pc",   32'(bus.page_cross), 32'h0);
    chk("indy_nc_xcyc", 32'(bus.xcyc), 32'h2);
    chk("indy_nc_lat",  32'(lat), 32'd3);

    // Two wait cycles per pointer read
    rd_delay = 2;
    n_unstab = 0;
    addr_log.delete();
    run_op(AM_INDY, 8'h40, 8'h00, 8'h00, 8'h20, 1'b0, lat);
    chk("indy_w_ea",     32'(bus.ea), 32'h2110);
    chk("indy_w_xcyc",   32'(bus.xcyc), 32'h3);
    chk("indy_w_lat",    32'(lat), 32'd8);
    chk("indy_w_stable", 32'(n_unstab), 32'd0);
    chk("indy_w_nrd",    32'(addr_log.size()), 32'd2);

    // start during PTR_HI is dropped
    rd_delay = 1;
    n_ev = 0;
    issue(AM_INDX, 8'hFE, 8'h00, 8'h01, 8'h00, 1'b0); // cycle 1: PTR_LO
    tick();                                            // cycle 2: read completes
    tick();                                            // cycle 3: PTR_HI
    chk("busy_ptr_hi", 32'(bus.busy), 32'h1);
    issue(AM_ZP, 8'h99, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("ign_n_ev", 32'(n_ev), 32'd1);
    chk("ign_ea",   32'(bus.ea), 32'h1234);
    chk("ign_busy", 32'(bus.busy), 32'h0);

    // Reset in PTR_HI, then a stray rd_valid
    n_ev = 0;
    issue(AM_INDX, 8'hFE, 8'h00, 8'h01, 8'h00, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    extra_valid = 1'b1;
    tick();
    extra_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mrst_n_ev",   32'(n_ev), 32'd0);
    chk("mrst_rd_req", 32'(bus.rd_req), 32'h0);
    chk("mrst_rd_addr", 32'(bus.rd_addr), 32'h0);
    chk("mrst_ea",     32'(bus.ea), 32'h0);
    chk("mrst_pc",     32'(bus.page_cross), 32'h0);
    chk("mrst_xcyc",   32'(bus.xcyc), 32'h0);
    chk("mrst_busy",   32'(bus.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_cpu_agu
`default_nettype wire
